// File: rtl/ram_loader.sv
// ram_loader: accepts a burst of words over a valid/ready stream and writes
// them to consecutive addresses of a RAM write port (wrapping at the top of
// the address space). It also keeps a running modulo-2^DATA_W checksum of
// the burst.
//
// Handshake: a word moves on a rising edge where i_in_valid=1 and
// o_in_ready=1. The source may hold i_in_valid low for any number of cycles.
// i_in_data is only looked at on a handshake edge. o_in_ready does not
// depend on i_in_valid.
module ram_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_checksum,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_checksum;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;

  logic              w_in_ready;
  logic              w_handshake;
  logic              w_start_accept;

  // LOAD keeps one extra cycle after the last handshake, with ready low,
  // so the final registered write lands before FINISH raises done.
  assign w_in_ready     = (r_state == S_LOAD) && (r_remaining != '0);
  assign w_handshake    = w_in_ready && i_in_valid;
  assign w_start_accept = (r_state == S_IDLE) && i_start;

  assign o_in_ready = w_in_ready;
  assign o_ram_we   = r_ram_we;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_din  = r_ram_din;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_FINISH);
  assign o_checksum = r_checksum;
  assign o_state    = r_state;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (i_length == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_remaining == '0) begin
          w_next_state = S_FINISH;
        end
      end
      S_FINISH: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping: latch parameters on start, advance per handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_checksum  <= '0;
    end else if (w_start_accept) begin
      r_addr      <= i_base_addr;
      r_remaining <= i_length;
      r_checksum  <= '0;
    end else if (w_handshake) begin
      r_addr      <= r_addr + ADDR_ONE;
      r_remaining <= r_remaining - CNT_ONE;
      r_checksum  <= r_checksum + i_in_data;
    end
  end

  // Registered RAM write port: one-cycle pulse after each handshake,
  // address/data hold their last values otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ram_we <= w_handshake;
      if (w_handshake) begin
        r_ram_addr <= r_addr;
        r_ram_din  <= i_in_data;
      end
    end
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the RAM word-address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the RAM data width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  in  1  SHALL request a load burst; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_W  SHALL give the first RAM address; sampled with start.
REQ-007 length  in  ADDR_W+1  SHALL give the word count, 0..2^ADDR_W; sampled with start.
REQ-008 in_valid  in  1  SHALL mark in_data as valid (source side).
REQ-009 in_data  in  DATA_W  SHALL carry the word to store.
REQ-010 in_ready  out  1  SHALL indicate the loader accepts a word this cycle.
REQ-011 ram_we  out  1  SHALL be the write enable to the dual-port RAM write port.
REQ-012 ram_addr  out  ADDR_W  SHALL be the RAM write address.
REQ-013 ram_din  out  DATA_W  SHALL be the RAM write data.
REQ-014 busy  out  1  SHALL be high in every state except IDLE.
REQ-015 done  out  1  SHALL be a one-cycle pulse when a burst completes.
REQ-016 checksum  out  DATA_W  SHALL hold the modulo-2^DATA_W sum of the words in the current or last burst.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, LOAD, FINISH.
REQ-018 IDLE with start=1 and length>0 SHALL latch base_addr and length, clear checksum to 0, and go to LOAD on the next edge.
REQ-019 IDLE with start=1 and length=0 SHALL clear checksum, go to FINISH, and perform no RAM write.
REQ-020 In LOAD, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-021 A handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1; no word is taken otherwise, and in_data is ignored.
REQ-022 A handshake at edge N SHALL drive registered ram_we=1, ram_addr=current address and ram_din=in_data for the cycle after N, that is, one-cycle latency.
REQ-023 ram_we SHALL be 0 in every cycle not following a handshake; ram_addr and ram_din SHALL hold their last values.
REQ-024 The write address SHALL increment by 1 per handshake and wrap modulo 2^ADDR_W (for example 0xFF goes to 0x00).
REQ-025 checksum SHALL add each accepted word at its handshake edge; carry out SHALL be discarded.
REQ-026 The remaining count SHALL decrement per handshake; the handshake taking it to 0 SHALL move the FSM to FINISH.
REQ-027 in_ready SHALL therefore drop in the cycle after the last handshake, while the last write is in flight.
REQ-028 FINISH SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-029 done SHALL therefore coincide with the cycle after the last ram_we cycle, or with the cycle after start when length=0.
REQ-030 start asserted while busy=1 SHALL be ignored, including in the FINISH cycle.
REQ-031 in_valid stalls of any length during LOAD SHALL be tolerated without timeout.
REQ-032 length=2^ADDR_W SHALL write every address exactly once, ending at base_addr-1 modulo 2^ADDR_W.
REQ-033 checksum SHALL hold its value from FINISH until the next accepted start.

Reset
REQ-034 rst_n low SHALL immediately set: state=IDLE, in_ready=0, ram_we=0, ram_addr=0, ram_din=0, busy=0, done=0, checksum=0, internal counters=0.
REQ-035 Reset asserted mid-burst SHALL abort the burst with no further writes; words already written stay in RAM.
REQ-036 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-037 Basic burst: base_addr=0x10, length=3, in_valid held high with data 0x0001, 0x0002, 0x0003 -> writes at 0x10/0x11/0x12 in three consecutive cycles, starting one cycle after each handshake; done one cycle after the last write; checksum=0x0006.
REQ-038 Wrap: base_addr=0xFE, length=4 -> writes to 0xFE, 0xFF, 0x00, 0x01 in that order.
REQ-039 Stall: length=2, in_valid low for 5 cycles between the words -> exactly 2 ram_we pulses, busy high throughout, single done pulse.
REQ-040 Zero length: start with length=0 -> no ram_we; done pulses in the cycle after start; checksum=0.
REQ-041 Overflow and ignore: words 0xFFFF and 0x0002 -> checksum=0x0001; start re-pulsed mid-burst -> no effect on address or count.
REQ-042 Mid-burst reset: rst_n low after 2 of 5 words -> all outputs 0 asynchronously; a new start with base_addr=0x40, length=1 works normally.
